keyb_scancode_history_disp: RTL and testbench

//  Captures PS/2 scancode bytes and shows the last NUM_DIGITS/2 accepted make codes on a

---
 rtl/keyb_scancode_history_disp_pkg.sv | 20 ++
 rtl/conv_hex_7seg.sv | 30 +++
 rtl/keyb_scancode_history_disp.sv | 157 +++++++++++++++
 tb/tb_keyb_scancode_history_disp.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/keyb_scancode_history_disp_pkg.sv
// rtl/keyb_scancode_history_disp_pkg.sv - shared constants and prefix FSM encoding for the scancode history display
package keyb_scancode_history_disp_pkg;

   // Segment bus layout {a,b,c,d,e,f,g,dp}, active-high before polarity is applied
   localparam int SEG_A  = 7;
   localparam int SEG_G  = 1;
   localparam int SEG_DP = 0;
   localparam logic [7:0] SEG_BLANK = 8'h00;

   localparam logic [7:0] PFX_EXT = 8'hE0;
   localparam logic [7:0] PFX_BRK = 8'hF0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } pfx_state_t;

endpackage

// File: rtl/conv_hex_7seg.sv
// rtl/conv_hex_7seg.sv - hex nibble to active-high {a..g} segment pattern
module conv_hex_7seg (
   input  logic [3:0] nibble,
   output logic [6:0] segs
);

   always_comb begin
      segs = 7'h00;
      case (nibble)
         4'h0: segs = 7'h7E;
         4'h1: segs = 7'h30;
         4'h2: segs = 7'h6D;
         4'h3: segs = 7'h79;
         4'h4: segs = 7'h33;
         4'h5: segs = 7'h5B;
         4'h6: segs = 7'h5F;
         4'h7: segs = 7'h70;
         4'h8: segs = 7'h7F;
         4'h9: segs = 7'h7B;
         4'hA: segs = 7'h77;
         4'hB: segs = 7'h1F;
         4'hC: segs = 7'h4E;
         4'hD: segs = 7'h3D;
         4'hE: segs = 7'h4F;
         4'hF: segs = 7'h47;
         default: segs = 7'h00;
      endcase
   end

endmodule

// File: rtl/keyb_scancode_history_disp.sv
// rtl/keyb_scancode_history_disp.sv - PS/2 make-code history shown on a multiplexed 7-segment display
module keyb_scancode_history_disp
   import keyb_scancode_history_disp_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int REFRESH_DIV   = 50000,
   parameter int FILTER_BREAK  = 1,
   parameter int ANODE_ACT_LOW = 1,
   parameter int SEG_ACT_LOW   = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            scancode,
   input  logic                  scan_valid,
   output logic [7:0]            seg,
   output logic [NUM_DIGITS-1:0] anodes,
   output logic                  new_key
);

   localparam int HIST = NUM_DIGITS / 2;
   localparam int IW   = $clog2(NUM_DIGITS);
   localparam int DW   = $clog2(REFRESH_DIV);
   localparam logic [7:0] SEG_OFF = (SEG_ACT_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;
   localparam logic [NUM_DIGITS-1:0] AN_OFF = (ANODE_ACT_LOW != 0) ? '1 : '0;

   logic                  valid_q;
   logic                  accept;
   pfx_state_t            state;
   logic                  store_en;
   logic                  store_ext;
   logic [HIST-1:0][7:0]  slot_byte;
   logic [HIST-1:0]       slot_ext;
   logic [HIST-1:0]       slot_vld;
   logic [DW-1:0]         div;
   logic [IW-1:0]         idx;
   logic [7:0]            cur_byte;
   logic                  cur_ext;
   logic                  cur_vld;
   logic [3:0]            nibble;
   logic [6:0]            hex_segs;
   logic [7:0]            seg_on;
   logic [NUM_DIGITS-1:0] an_sel;

   assign accept = scan_valid & ~valid_q;

   // Which accepted bytes become history entries, and whether they carry the E0 flag
   always_comb begin
      store_en  = 1'b0;
      store_ext = 1'b0;
      if (accept) begin
         if (FILTER_BREAK == 0) begin
            store_en = 1'b1;
         end else begin
            case (state)
               ST_IDLE: store_en = (scancode != PFX_BRK) && (scancode != PFX_EXT);
               ST_EXT: begin
                  store_en  = (scancode != PFX_BRK) && (scancode != PFX_EXT);
                  store_ext = 1'b1;
               end
               default: store_en = 1'b0;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else if (accept && (FILTER_BREAK != 0)) begin
         case (state)
            ST_IDLE: begin
               if (scancode == PFX_BRK)      state <= ST_BRK;
               else if (scancode == PFX_EXT) state <= ST_EXT;
            end
            ST_EXT: begin
               if (scancode == PFX_BRK)      state <= ST_EXT_BRK;
               else if (scancode != PFX_EXT) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // valid_q resets high so a strobe held across reset release is not taken
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q   <= 1'b1;
         new_key   <= 1'b0;
         slot_byte <= '0;
         slot_ext  <= '0;
         slot_vld  <= '0;
      end else begin
         valid_q <= scan_valid;
         new_key <= store_en;
         if (store_en) begin
            for (int k = 1; k < HIST; k++) begin
               slot_byte[k] <= slot_byte[k-1];
               slot_ext[k]  <= slot_ext[k-1];
               slot_vld[k]  <= slot_vld[k-1];
            end
            slot_byte[0] <= scancode;
            slot_ext[0]  <= store_ext;
            slot_vld[0]  <= 1'b1;
         end
      end
   end

   // Digit pair k shows slot k; even digit is the low nibble and carries the DP
   always_comb begin
      cur_byte = '0;
      cur_ext  = 1'b0;
      cur_vld  = 1'b0;
      for (int k = 0; k < HIST; k++) begin
         if ((int'(idx) >> 1) == k) begin
            cur_byte = slot_byte[k];
            cur_ext  = slot_ext[k];
            cur_vld  = slot_vld[k];
         end
      end
   end

   assign nibble = idx[0] ? cur_byte[7:4] : cur_byte[3:0];

   conv_hex_7seg u_hex (
      .nibble (nibble),
      .segs   (hex_segs)
   );

   always_comb begin
      seg_on = SEG_BLANK;
      if (cur_vld) begin
         seg_on[SEG_A:SEG_G] = hex_segs;
         seg_on[SEG_DP]      = cur_ext & ~idx[0];
      end
   end

   assign an_sel = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;

   always_ff @(posedge clk) begin
      if (reset) begin
         div    <= '0;
         idx    <= '0;
         seg    <= SEG_OFF;
         anodes <= AN_OFF;
      end else begin
         if (div == DW'(REFRESH_DIV - 1)) begin
            div <= '0;
            idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
         end else begin
            div <= div + 1'b1;
         end
         seg    <= seg_on ^ SEG_OFF;
         anodes <= an_sel ^ AN_OFF;
      end
   end

endmodule

// File: tb/tb_keyb_scancode_history_disp.sv
// tb/tb_keyb_scancode_history_disp.sv - self-checking bench for the scancode history display
module tb_keyb_scancode_history_disp;

   localparam int ND = 4;
   localparam int RD = 4;

   typedef struct packed {
      logic [7:0] code;
      logic       st;
      logic       ext;
   } vec_t;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    scancode;
   logic          scan_valid;
   logic [7:0]    seg, seg_raw;
   logic [ND-1:0] anodes, anodes_raw;
   logic          new_key, new_key_raw;

   int errors = 0;
   int checks = 0;
   int nk_cnt = 0;
   int nk_raw = 0;
   int nk_seen = 0;

   exp_t       exp_q[$];
   logic [7:0] hb[2];
   logic       he[2];
   logic       hv[2];
   logic [6:0] hex_tab[16];
   vec_t       vecs[14];

   always #5 clk = ~clk;

   keyb_scancode_history_disp #(
      .NUM_DIGITS(ND), .REFRESH_DIV(RD), .FILTER_BREAK(1), .ANODE_ACT_LOW(1), .SEG_ACT_LOW(1)
   ) u_dut (
      .clk(clk), .reset(reset), .scancode(scancode), .scan_valid(scan_valid),
      .seg(seg), .anodes(anodes), .new_key(new_key)
   );

   keyb_scancode_history_disp #(
      .NUM_DIGITS(ND), .REFRESH_DIV(RD), .FILTER_BREAK(0), .ANODE_ACT_LOW(1), .SEG_ACT_LOW(1)
   ) u_dut_raw (
      .clk(clk), .reset(reset), .scancode(scancode), .scan_valid(scan_valid),
      .seg(seg_raw), .anodes(anodes_raw), .new_key(new_key_raw)
   );

   always @(negedge clk) begin
      if (new_key)     nk_cnt++;
      if (new_key_raw) nk_raw++;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   function automatic logic [7:0] exp_seg(input logic [7:0] b, input logic v, input logic e, input int d);
      logic [3:0] n;
      logic [7:0] on;
      if (!v) return 8'hFF;
      n  = (d % 2 == 1) ? b[7:4] : b[3:0];
      on = {hex_tab[n], (d % 2 == 0) && e};
      return ~on;
   endfunction

   // Each new_key pulse consumes one expected store; the model history follows the pops
   task automatic drain(input string tag);
      exp_t e;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         while (nk_seen < nk_cnt) begin
            nk_seen++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL %s_new_key: got unexpected pulse expected none", tag);
            end else begin
               e = exp_q.pop_front();
               hb[1] = hb[0]; he[1] = he[0]; hv[1] = hv[0];
               hb[0] = e.code; he[0] = e.ext; hv[0] = 1'b1;
            end
         end
      end
      check({tag, "_pending"}, exp_q.size(), 0);
   endtask

   task automatic send(input string tag, input logic [7:0] c, input logic st, input logic ext, input int hold);
      if (st) exp_q.push_back({c, ext});
      @(negedge clk);
      scancode   = c;
      scan_valid = 1'b1;
      repeat (hold) @(negedge clk);
      scan_valid = 1'b0;
      repeat (2) @(negedge clk);
      drain(tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      hv[0] = 1'b0; hv[1] = 1'b0;
      exp_q.delete();
      nk_seen = nk_cnt;
   endtask

   task automatic check_display(input string tag, input int which,
                                input logic [7:0] b0, input logic v0, input logic e0,
                                input logic [7:0] b1, input logic v1, input logic e1);
      logic [7:0]    cap[ND];
      bit            seen[ND];
      logic [ND-1:0] act;
      logic [7:0]    s;
      int            bad;
      bad = 0;
      for (int d = 0; d < ND; d++) begin cap[d] = 8'h00; seen[d] = 0; end
      for (int c = 0; c < 3 * ND * RD; c++) begin
         @(negedge clk);
         act = (which == 1) ? ~anodes_raw : ~anodes;
         s   = (which == 1) ? seg_raw : seg;
         if ($countones(act) != 1) bad++;
         else for (int d = 0; d < ND; d++) if (act[d]) begin cap[d] = s; seen[d] = 1; end
      end
      check({tag, "_onehot"}, bad, 0);
      for (int d = 0; d < ND; d++)
         check($sformatf("%s_digit%0d", tag, d), seen[d] ? 32'(cap[d]) : 32'hDEAD,
               (d < 2) ? 32'(exp_seg(b0, v0, e0, d)) : 32'(exp_seg(b1, v1, e1, d)));
   endtask

   initial begin
      logic [3:0] want_an;
      int         base;
      hex_tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                  7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
      vecs = '{{8'h1C, 1'b1, 1'b0}, {8'hF0, 1'b0, 1'b0}, {8'h1C, 1'b0, 1'b0},
               {8'hE0, 1'b0, 1'b0}, {8'h75, 1'b1, 1'b1}, {8'hE0, 1'b0, 1'b0},
               {8'hF0, 1'b0, 1'b0}, {8'h75, 1'b0, 1'b0}, {8'h11, 1'b1, 1'b0},
               {8'h22, 1'b1, 1'b0}, {8'h33, 1'b1, 1'b0}, {8'hE0, 1'b0, 1'b0},
               {8'hE0, 1'b0, 1'b0}, {8'h6B, 1'b1, 1'b1}};
      hb[0] = 8'h00; hb[1] = 8'h00; he[0] = 1'b0; he[1] = 1'b0; hv[0] = 1'b0; hv[1] = 1'b0;

      // Reset with scan_valid already high: outputs inactive, no byte taken afterwards
      reset      = 1'b1;
      scan_valid = 1'b1;
      scancode   = 8'h5A;
      repeat (3) @(negedge clk);
      check("rst_seg", seg, 8'hFF);
      check("rst_anodes", anodes, 4'hF);
      check("rst_new_key", new_key, 0);
      check("rst_raw_seg", seg_raw, 8'hFF);
      nk_seen = nk_cnt;
      reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         want_an = ~(4'b0001 << (i / 4));
         check($sformatf("mux_step%0d", i), anodes, want_an);
      end
      drain("rst_hold");
      check("rst_hold_raw", nk_raw, 0);
      scan_valid = 1'b0;
      repeat (2) @(negedge clk);
      check_display("blank", 0, hb[0], hv[0], he[0], hb[1], hv[1], he[1]);

      for (int i = 0; i < 14; i++) begin
         send($sformatf("vec%0d", i), vecs[i].code, vecs[i].st, vecs[i].ext, 1 + (i % 3));
         check_display($sformatf("vec%0d", i), 0, hb[0], hv[0], he[0], hb[1], hv[1], he[1]);
      end
      check_display("raw_vec", 1, 8'h6B, 1'b1, 1'b0, 8'hE0, 1'b1, 1'b0);

      // Held strobe counts once
      send("held", 8'h2A, 1'b1, 1'b0, 20);
      check_display("held", 0, hb[0], hv[0], he[0], hb[1], hv[1], he[1]);

      // Pending break prefix is forgotten across reset
      send("pre_rst", 8'hF0, 1'b0, 1'b0, 1);
      do_reset();
      send("post_rst", 8'h1C, 1'b1, 1'b0, 1);
      check_display("post_rst", 0, hb[0], hv[0], he[0], hb[1], hv[1], he[1]);
      check("post_rst_byte", hb[0], 8'h1C);

      // Filter disabled: prefixes stored raw, no DP
      do_reset();
      base = nk_raw;
      send("raw_f0", 8'hF0, 1'b0, 1'b0, 1);
      send("raw_1c", 8'h1C, 1'b0, 1'b0, 1);
      check("raw_new_key_count", nk_raw - base, 2);
      check_display("raw", 1, 8'h1C, 1'b1, 1'b0, 8'hF0, 1'b1, 1'b0);
      check_display("filt_blank", 0, hb[0], hv[0], he[0], hb[1], hv[1], he[1]);

      drain("final");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
